// File: rtl/keccak_obi_state_slave_if.sv
// keccak_obi_state_slave_if: OBI request/response bundle between the crossbar and the state slave
interface keccak_obi_state_slave_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
   modport slave (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/keccak_obi_state_slave.sv
// keccak_obi_state_slave: OBI window onto the Keccak state plus a single-permutation sequencer
module keccak_obi_state_slave #(
   parameter bit STALL_ON_BUSY = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   keccak_obi_state_slave_if.slave slave,
   output logic [1599:0]          keccak_din_o,
   output logic                   keccak_start_o,
   input  logic [1599:0]          keccak_dout_i,
   input  logic                   keccak_done_i,
   output logic                   keccak_int_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   logic [0:0]        fsm_q;
   logic [49:0][31:0] st_q;
   logic              ie_q, done_q, start_q, int_q, rvalid_q;
   logic [31:0]       rdata_q, rd_data;
   logic [5:0]        w, wi;
   logic              busy, is_st, is_ctrl, is_stat, gnt, wr, go, cap, ie_n, done_n;
   logic              unused_addr;
   assign unused_addr = ^{slave.addr[31:8], slave.addr[1:0]};
   assign busy = fsm_q == BUSY;
   assign w = slave.addr[7:2];
   assign is_st = w < 6'd50;
   assign is_ctrl = w == 6'd50;
   assign is_stat = w == 6'd51;
   assign wi = is_st ? w : 6'd0;
   // rst_ni gating keeps gnt low while reset is held mid-transaction
   assign gnt = slave.req & rst_ni & ~(STALL_ON_BUSY & busy & is_st);
   assign wr = gnt & slave.we;
   assign go = wr & is_ctrl & slave.be[0] & slave.wdata[0] & ~busy;
   assign cap = busy & keccak_done_i;
   assign ie_n = (wr & is_ctrl & slave.be[0]) ? slave.wdata[1] : ie_q;
   assign done_n = cap ? 1'b1 : go ? 1'b0 : (wr & is_stat & slave.be[0] & slave.wdata[1]) ? 1'b0 : done_q;
   assign rd_data = is_st ? (busy ? 32'd0 : st_q[wi]) :
                    is_ctrl ? {30'd0, ie_q, 1'b0} :
                    is_stat ? {30'd0, done_q, busy} : 32'd0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q    <= IDLE;
         st_q     <= '0;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         start_q  <= 1'b0;
         int_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         fsm_q    <= go ? BUSY : cap ? IDLE : fsm_q;
         ie_q     <= ie_n;
         done_q   <= done_n;
         start_q  <= go;
         int_q    <= done_n & ie_n;
         rvalid_q <= gnt;
         rdata_q  <= (gnt & ~slave.we) ? rd_data : 32'd0;
         // capture outranks any state write in the same cycle; busy writes are dropped
         if (cap) st_q <= keccak_dout_i;
         else if (wr & is_st & ~busy)
            for (int b = 0; b < 4; b++)
               if (slave.be[b]) st_q[wi][8*b +: 8] <= slave.wdata[8*b +: 8];
      end
   end
   assign slave.gnt = gnt;
   assign slave.rvalid = rvalid_q;
   assign slave.rdata = rdata_q;
   assign keccak_din_o = st_q;
   assign keccak_start_o = start_q;
   assign keccak_int_o = int_q;
endmodule

// File: tb/tb_keccak_obi_state_slave.sv
// tb_keccak_obi_state_slave: directed checks of the Keccak OBI state slave
module tb_keccak_obi_state_slave;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [1599:0] din, dout = '0;
   logic start, done = 1'b0, irq;
   int checks = 0, errors = 0;
   logic [31:0] r;
   int n;
   keccak_obi_state_slave_if bif();
   keccak_obi_state_slave #(.STALL_ON_BUSY(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .slave(bif), .keccak_din_o(din), .keccak_start_o(start),
      .keccak_dout_i(dout), .keccak_done_i(done), .keccak_int_o(irq));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] word(input logic [7:0] tag, input int i);
      return {tag, i[7:0], 16'h5A5A};
   endfunction
   function automatic logic [1599:0] block(input logic [7:0] tag);
      logic [1599:0] v;
      for (int i = 0; i < 50; i++) v[32*i +: 32] = word(tag, i);
      return v;
   endfunction
   task automatic xfer(input logic we, input logic [5:0] w, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output int waits);
      waits = 0;
      @(posedge clk); #1;
      bif.req = 1'b1; bif.we = we; bif.addr = {24'd0, w, 2'b00}; bif.wdata = wd; bif.be = be;
      @(negedge clk);
      while (!bif.gnt && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!bif.gnt) chk("gnt_timeout", 32'(bif.gnt), 32'd1);
      @(posedge clk); #1;
      bif.req = 1'b0; bif.we = 1'b0;
      @(negedge clk);
      chk("rvalid", 32'(bif.rvalid), 32'd1);
      rd = bif.rdata;
   endtask
   task automatic pulse_done(input logic [1599:0] v);
      @(posedge clk); #1;
      dout = v; done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      bif.req = 1'b0; bif.we = 1'b0; bif.be = '0; bif.addr = '0; bif.wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_int", 32'(irq), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      // reset asserted while a read is being granted
      xfer(1'b1, 6'd5, 32'h12345678, 4'hF, r, n);
      xfer(1'b0, 6'd5, 32'd0, 4'hF, r, n);
      chk("w5_rd", r, 32'h12345678);
      @(posedge clk); #1;
      bif.req = 1'b1; bif.we = 1'b0; bif.addr = {24'd0, 6'd5, 2'b00}; bif.be = 4'hF;
      @(negedge clk);
      chk("pre_rst_gnt", 32'(bif.gnt), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(bif.gnt), 32'd0);
      chk("mid_rst_rvalid", 32'(bif.rvalid), 32'd0);
      chk("mid_rst_rdata", bif.rdata, 32'd0);
      chk("mid_rst_din", 32'(|din), 32'd0);
      chk("mid_rst_int", 32'(irq), 32'd0);
      @(posedge clk); #1 bif.req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("rst_status", r, 32'd0);
      xfer(1'b0, 6'd5, 32'd0, 4'hF, r, n);
      chk("rst_w5", r, 32'd0);
      // byte enables
      xfer(1'b1, 6'd3, 32'hAABBCCDD, 4'b0101, r, n);
      xfer(1'b0, 6'd3, 32'd0, 4'hF, r, n);
      chk("be_rd", r, 32'h00BB00DD);
      chk("be_din", din[127:96], 32'h00BB00DD);
      // back-to-back write then read of the same word
      @(posedge clk); #1;
      bif.req = 1'b1; bif.we = 1'b1; bif.addr = {24'd0, 6'd7, 2'b00}; bif.wdata = 32'hCAFEF00D; bif.be = 4'hF;
      @(negedge clk);
      chk("b2b_gnt_wr", 32'(bif.gnt), 32'd1);
      @(posedge clk); #1;
      bif.we = 1'b0;
      @(negedge clk);
      chk("b2b_rvalid_wr", 32'(bif.rvalid), 32'd1);
      chk("b2b_rdata_wr", bif.rdata, 32'd0);
      @(posedge clk); #1 bif.req = 1'b0;
      @(negedge clk);
      chk("b2b_rvalid_rd", 32'(bif.rvalid), 32'd1);
      chk("b2b_rdata_rd", bif.rdata, 32'hCAFEF00D);
      @(negedge clk);
      chk("rvalid_idle", 32'(bif.rvalid), 32'd0);
      // full permutation
      for (int i = 0; i < 50; i++) xfer(1'b1, 6'(i), word(8'h11, i), 4'hF, r, n);
      chk("load_din49", din[1599:1568], 32'h11315A5A);
      xfer(1'b1, 6'd50, 32'h3, 4'h1, r, n);
      chk("start_hi", 32'(start), 32'd1);
      @(negedge clk);
      chk("start_lo", 32'(start), 32'd0);
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("status_busy", r, 32'h1);
      xfer(1'b0, 6'd50, 32'd0, 4'hF, r, n);
      chk("ctrl_rd_busy", r, 32'h2);
      chk("ctrl_no_stall", 32'(n), 32'd0);
      // state read stalls until the cycle after done
      @(posedge clk); #1;
      bif.req = 1'b1; bif.we = 1'b0; bif.addr = 32'd0; bif.be = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_gnt", 32'(bif.gnt), 32'd0);
      end
      @(posedge clk); #1;
      dout = block(8'hC3); done = 1'b1;
      @(negedge clk);
      chk("stall_gnt_done", 32'(bif.gnt), 32'd0);
      @(posedge clk); #1 done = 1'b0;
      @(negedge clk);
      chk("stall_gnt_after", 32'(bif.gnt), 32'd1);
      chk("int_set", 32'(irq), 32'd1);
      @(posedge clk); #1 bif.req = 1'b0;
      @(negedge clk);
      chk("stall_rvalid", 32'(bif.rvalid), 32'd1);
      chk("stall_rdata", bif.rdata, 32'hC3005A5A);
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("status_done", r, 32'h2);
      for (int i = 1; i < 50; i++) begin
         xfer(1'b0, 6'(i), 32'd0, 4'hF, r, n);
         chk("perm_word", r, word(8'hC3, i));
      end
      chk("perm_din", din[1599:1568], 32'hC3315A5A);
      xfer(1'b1, 6'd51, 32'h2, 4'h1, r, n);
      chk("int_clr", 32'(irq), 32'd0);
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("status_clr", r, 32'd0);
      // START while busy, done colliding with W1C
      xfer(1'b1, 6'd50, 32'h3, 4'h1, r, n);
      chk("start2_hi", 32'(start), 32'd1);
      xfer(1'b1, 6'd50, 32'h1, 4'h1, r, n);
      chk("start_busy_none", 32'(start), 32'd0);
      xfer(1'b0, 6'd50, 32'd0, 4'hF, r, n);
      chk("ie_busy_write", r, 32'd0);
      xfer(1'b1, 6'd50, 32'h2, 4'h1, r, n);
      @(posedge clk); #1;
      bif.req = 1'b1; bif.we = 1'b1; bif.addr = {24'd0, 6'd51, 2'b00}; bif.wdata = 32'h2; bif.be = 4'h1;
      dout = block(8'h3C); done = 1'b1;
      @(negedge clk);
      chk("w1c_gnt", 32'(bif.gnt), 32'd1);
      @(posedge clk); #1;
      bif.req = 1'b0; bif.we = 1'b0; done = 1'b0;
      @(negedge clk);
      chk("collide_int", 32'(irq), 32'd1);
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("collide_done", r, 32'h2);
      xfer(1'b0, 6'd0, 32'd0, 4'hF, r, n);
      chk("collide_w0", r, 32'h3C005A5A);
      xfer(1'b1, 6'd51, 32'h2, 4'h1, r, n);
      // done while idle is ignored
      pulse_done(block(8'hE7));
      xfer(1'b0, 6'd0, 32'd0, 4'hF, r, n);
      chk("idle_done_w0", r, 32'h3C005A5A);
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("idle_done_status", r, 32'd0);
      chk("idle_done_int", 32'(irq), 32'd0);
      xfer(1'b1, 6'd60, 32'hFFFFFFFF, 4'hF, r, n);
      xfer(1'b0, 6'd60, 32'd0, 4'hF, r, n);
      chk("oor_rd", r, 32'd0);
      // reset while busy, late done ignored
      xfer(1'b1, 6'd50, 32'h3, 4'h1, r, n);
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("rb_busy", r, 32'h1);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      pulse_done(block(8'hE7));
      xfer(1'b0, 6'd51, 32'd0, 4'hF, r, n);
      chk("rb_status", r, 32'd0);
      xfer(1'b0, 6'd0, 32'd0, 4'hF, r, n);
      chk("rb_w0", r, 32'd0);
      chk("rb_int", 32'(irq), 32'd0);
      chk("rb_din", 32'(|din), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/keccak_obi_state_slave.md
# keccak_obi_state_slave

OBI responder that exposes the 1600-bit Keccak state and a small control/status register set as a memory-mapped window on the external crossbar slave port of the X-HEEP system. It handles the slave end of the same OBI bus that the accelerator wrapper uses as a master. It also sequences a single permutation on an attached Keccak core: start pulse, busy tracking, result capture and a level interrupt. One instance sits between the system's external-xbar slave request/response pair and the permutation datapath.

## Interface
- STALL_ON_BUSY, 1, 1: state-word accesses are not granted while BUSY; 0: they are granted, writes are dropped and reads return 0.
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- slave_req_i  input  obi_req_t  OBI request; fields req, we, be[3:0], addr[31:0], wdata[31:0].
- slave_resp_o  output  obi_resp_t  OBI response; fields gnt, rvalid, rdata[31:0].
- keccak_din_o  output  1600  state buffer, continuously driven; word i = bits [32i+31:32i].
- keccak_start_o  output  1  one-cycle start pulse to the core.
- keccak_dout_i  input  1600  permutation result, valid when keccak_done_i is high.
- keccak_done_i  input  1  one-cycle completion pulse from the core.
- keccak_int_o  output  1  level interrupt, equal to DONE & IE, registered.

## Operation
- Decode uses addr[7:2] (word index w); higher address bits are ignored because the crossbar has already decoded the window.
  - w 0..49: state word w, read/write, byte enables honoured.
  - w 50: CTRL. bit0 START is write-only and reads 0. bit1 IE is read/write.
  - w 51: STATUS. bit0 BUSY is read-only. bit1 DONE is sticky and write-1-to-clear.
  - w 52..63: reads return 0, writes are ignored. They are still granted and still answered.
- For CTRL and STATUS, only be[0] matters; all other bits read 0.
- Grant:
  - gnt = req, except when STALL_ON_BUSY=1, BUSY=1 and w<50; then gnt=0 until BUSY falls.
  - A granted access commits its write in the grant cycle.
  - Read data is sampled in the grant cycle.
- FSM, two states, IDLE and BUSY:
  - IDLE: a granted CTRL write with be[0]=1 and wdata[0]=1 raises keccak_start_o next cycle, clears DONE and moves to BUSY.
  - BUSY: keccak_done_i loads keccak_dout_i into all 50 state words, sets DONE and moves to IDLE.
  - A START write while BUSY is ignored (no pulse). The IE part of that write still takes effect.
  - keccak_done_i in IDLE is ignored.
- Simultaneous events:
  - DONE set by keccak_done_i and W1C in the same cycle: set wins.
  - State write granted in the same cycle as the capture (only possible with STALL_ON_BUSY=0): the capture wins.
- Reset mid-operation: everything returns to reset values and state goes to IDLE. A later keccak_done_i is ignored.

## Timing
- Reset values: gnt 0, rvalid 0, rdata 0, keccak_start_o 0, keccak_int_o 0, keccak_din_o all 0; IE, DONE and BUSY all 0.
- gnt is combinational from req and BUSY; no other output is combinational.
- rvalid is exactly 1 cycle after each grant, for reads and writes alike. Back-to-back grants give back-to-back rvalids. rdata is valid only with rvalid and is 0 otherwise.
- Start sequence: START write granted at cycle t → keccak_start_o=1 and BUSY=1 at t+1, keccak_start_o=0 at t+2.
- Completion: keccak_done_i at cycle d → state updated, BUSY=0, DONE=1 at d+1; keccak_int_o=1 at d+1 if IE=1.
- A state access stalled by BUSY is granted at d+1 at the earliest, and reads the captured result.
- Read-after-write to the same word in consecutive grants returns the new data.

## Test plan
- Reset: assert rst_ni=0 mid-transaction → all outputs 0; after release, a read of w=51 returns 0x0 with rvalid 1 cycle after gnt.
- Byte-enable write: write w=3 with wdata 0xAABBCCDD and be 4'b0101, then read w=3 → 0x00BB00DD; keccak_din_o[127:96] equals 0x00BB00DD.
- Full permutation: load words 0..49, write CTRL=0x3 → one-cycle start pulse and STATUS reads 0x1. Drive done with keccak_dout_i = pattern → next cycle STATUS reads 0x2, keccak_int_o=1, words 0..49 read back the pattern. Write STATUS=0x2 → int drops next cycle.
- Stall: with STALL_ON_BUSY=1, read w=0 while BUSY → gnt low until the cycle after done, then rdata equals dout word 0. A CTRL read during BUSY is granted immediately.
- Collisions: START write while BUSY → no second pulse. done plus STATUS W1C in the same cycle → DONE=1. Out-of-range w=60 write then read → 0.
- Reset during BUSY: start, pulse rst_ni, then drive keccak_done_i → STATUS 0x0, state words 0, no interrupt.
